// File: rtl/mips_pkg.sv
// Shared datapath definitions for the multicycle MIPS core: widths, mult/div op
// encodings and the multiply/divide sequencer states.
package mips_pkg;

    localparam int unsigned DATA_W = 32;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } md_state_t;

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor and keep the difference when non-negative.
module div_restore_step #(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W:0] rem,
    input  logic            dividend_bit,
    input  logic [DATA_W:0] divisor,
    output logic [DATA_W:0] rem_next_c,
    output logic            q_bit_c
);

    logic [DATA_W:0]   shifted;
    logic [DATA_W+1:0] diff;

    // Extra top bit of diff acts as the borrow / sign of the trial subtraction
    always_comb begin
        shifted    = {rem[DATA_W-1:0], dividend_bit};
        diff       = {1'b0, shifted} - {1'b0, divisor};
        q_bit_c    = ~diff[DATA_W+1];
        rem_next_c = q_bit_c ? diff[DATA_W:0] : shifted;
    end

endmodule

// File: rtl/mult_div_unit.sv
// Sequential signed multiply/divide unit feeding HI/LO: radix-2 Booth multiply
// and restoring divide on magnitudes, fixed DATA_W iterations plus a sign-fix cycle.
module mult_div_unit
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W = mips_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              op,
    input  logic [DATA_W-1:0] operand_a,
    input  logic [DATA_W-1:0] operand_b,
    output logic              busy,
    output logic              done,
    output logic              div_zero,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int unsigned CNT_W = $clog2(DATA_W) + 1;
    // Booth accumulator: (DATA_W+1)-bit upper half so a most-negative multiplicand
    // cannot overflow, DATA_W-bit multiplier, one extra Booth bit.
    localparam int unsigned ACC_W = 2 * DATA_W + 2;

    md_state_t         state;
    logic              op_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [CNT_W-1:0]  cnt;
    logic [ACC_W-1:0]  acc;
    logic [DATA_W:0]   rem;
    logic [DATA_W:0]   divisor;
    logic [DATA_W-1:0] quo;

    logic [DATA_W:0]   a_ext_c;
    logic [DATA_W:0]   upper_c;
    logic [ACC_W-1:0]  acc_next_c;
    logic [DATA_W:0]   rem_next_c;
    logic              q_bit_c;
    logic [DATA_W-1:0] quo_fix_c;
    logic [DATA_W-1:0] rem_fix_c;

    function automatic logic [DATA_W-1:0] neg_if(input logic s, input logic [DATA_W-1:0] v);
        return s ? (~v + DATA_W'(1)) : v;
    endfunction

    // Magnitude of -2^(DATA_W-1) is representable as an unsigned DATA_W value
    function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v);
        return neg_if(v[DATA_W-1], v);
    endfunction

    div_restore_step #(
        .DATA_W (DATA_W)
    ) u_div_step (
        .rem          (rem),
        .dividend_bit (quo[DATA_W-1]),
        .divisor      (divisor),
        .rem_next_c   (rem_next_c),
        .q_bit_c      (q_bit_c)
    );

    // Booth radix-2 step: add/subtract multiplicand, then arithmetic shift right
    always_comb begin
        a_ext_c = {a_q[DATA_W-1], a_q};
        upper_c = acc[ACC_W-1:DATA_W+1];
        case (acc[1:0])
            2'b01:   upper_c = upper_c + a_ext_c;
            2'b10:   upper_c = upper_c - a_ext_c;
            default: upper_c = acc[ACC_W-1:DATA_W+1];
        endcase
        acc_next_c = {upper_c[DATA_W], upper_c, acc[DATA_W:1]};
    end

    // Quotient negative when operand signs differ; remainder takes the dividend sign
    always_comb begin
        quo_fix_c = neg_if(a_q[DATA_W-1] ^ b_q[DATA_W-1], quo);
        rem_fix_c = neg_if(a_q[DATA_W-1], rem[DATA_W-1:0]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            op_q     <= OP_MULT;
            a_q      <= '0;
            b_q      <= '0;
            cnt      <= '0;
            acc      <= '0;
            rem      <= '0;
            divisor  <= '0;
            quo      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (op == OP_DIV && operand_b == '0) begin
                            done     <= 1'b1;
                            div_zero <= 1'b1;
                            state    <= DONE;
                        end else begin
                            op_q    <= op;
                            a_q     <= operand_a;
                            b_q     <= operand_b;
                            cnt     <= '0;
                            acc     <= {{(DATA_W + 1){1'b0}}, operand_b, 1'b0};
                            rem     <= '0;
                            quo     <= mag(operand_a);
                            divisor <= {1'b0, mag(operand_b)};
                            busy    <= 1'b1;
                            state   <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (op_q == OP_MULT) begin
                        acc <= acc_next_c;
                    end else begin
                        rem <= rem_next_c;
                        quo <= {quo[DATA_W-2:0], q_bit_c};
                    end
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(DATA_W - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (op_q == OP_MULT) begin
                        hi <= acc[2*DATA_W:DATA_W+1];
                        lo <= acc[DATA_W:1];
                    end else begin
                        hi <= rem_fix_c;
                        lo <= quo_fix_c;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus random
// operations compared against a 64-bit arithmetic reference model.
module tb_mult_div_unit;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         op;
    logic [W-1:0] operand_a;
    logic [W-1:0] operand_b;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int           checks = 0;
    int           failures = 0;
    logic [W-1:0] exp_hi = '0;
    logic [W-1:0] exp_lo = '0;

    mult_div_unit #(.DATA_W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: exact 64-bit signed arithmetic; division truncates toward zero
    task automatic model(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] mh, output logic [W-1:0] ml);
        longint sa;
        longint sb;
        longint p;
        longint q;
        longint r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (o == 1'b0) begin
            p  = sa * sb;
            mh = p[63:32];
            ml = p[31:0];
        end else begin
            q  = sa / sb;
            r  = sa % sb;
            mh = r[31:0];
            ml = q[31:0];
        end
    endtask

    task automatic run_op(input string tag, input logic o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input bit inj, input bit poke_done);
        int cyc;
        bit busy_ok;
        bit zero;
        logic [W-1:0] mh;
        logic [W-1:0] ml;
        zero = (o == 1'b1) && (b == '0);
        @(negedge clk);
        start = 1'b1; op = o; operand_a = a; operand_b = b;
        cyc = 0;
        busy_ok = 1'b1;
        forever begin
            @(negedge clk);
            cyc++;
            start = inj && (cyc == 5 || cyc == 20);
            if (start) begin
                op = ~o; operand_a = $urandom; operand_b = $urandom | 32'h1;
            end
            if (done === 1'b1 || cyc >= 100) break;
            if (busy !== (zero ? 1'b0 : 1'b1)) busy_ok = 1'b0;
        end
        if (!zero) begin
            model(o, a, b, mh, ml);
            exp_hi = mh;
            exp_lo = ml;
        end
        chk({tag, " latency"}, 64'(cyc), zero ? 64'd1 : 64'd34);
        chk({tag, " busy_during"}, 64'(busy_ok), 64'd1);
        chk({tag, " done"}, 64'(done), 64'd1);
        chk({tag, " div_zero"}, 64'(div_zero), 64'(zero));
        chk({tag, " busy_at_done"}, 64'(busy), 64'd0);
        chk({tag, " hi"}, 64'(hi), 64'(exp_hi));
        chk({tag, " lo"}, 64'(lo), 64'(exp_lo));
        if (poke_done) begin
            start = 1'b1; op = 1'b1; operand_a = 32'd9; operand_b = '0;
        end
        @(negedge clk);
        chk({tag, " done_single"}, 64'(done), 64'd0);
        chk({tag, " dz_single"}, 64'(div_zero), 64'd0);
        chk({tag, " hi_hold"}, 64'(hi), 64'(exp_hi));
        chk({tag, " lo_hold"}, 64'(lo), 64'(exp_lo));
        if (poke_done) begin
            @(negedge clk);
            start = 1'b0;
            chk({tag, " restart_done"}, 64'(done), 64'd1);
            chk({tag, " restart_dz"}, 64'(div_zero), 64'd1);
            chk({tag, " restart_busy"}, 64'(busy), 64'd0);
            @(negedge clk);
        end
    endtask

    logic [W-1:0] corner [5];

    initial begin
        logic         ro;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        corner[0] = 32'h0000_0000;
        corner[1] = 32'h0000_0001;
        corner[2] = 32'hFFFF_FFFF;
        corner[3] = 32'h8000_0000;
        corner[4] = 32'h7FFF_FFFF;

        reset = 1'b1; start = 1'b0; op = 1'b0; operand_a = '0; operand_b = '0;
        #12;
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        chk("rst div_zero", 64'(div_zero), 64'd0);
        chk("rst hi", 64'(hi), 64'd0);
        chk("rst lo", 64'(lo), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op("mul_7x-3", 1'b0, 32'd7, 32'hFFFF_FFFD, 1'b0, 1'b0);
        chk("mul_7x-3 const_hi", 64'(hi), 64'hFFFF_FFFF);
        chk("mul_7x-3 const_lo", 64'(lo), 64'hFFFF_FFEB);
        run_op("mul_min_min", 1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        chk("mul_min_min const_hi", 64'(hi), 64'h4000_0000);
        run_op("div_-7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        chk("div_-7/2 const_lo", 64'(lo), 64'hFFFF_FFFD);
        run_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        chk("div_ovf const_lo", 64'(lo), 64'h8000_0000);
        chk("div_ovf const_hi", 64'(hi), 64'h0);
        run_op("mul_3x5", 1'b0, 32'd3, 32'd5, 1'b0, 1'b0);
        run_op("div_9/0", 1'b1, 32'd9, 32'd0, 1'b0, 1'b0);
        chk("div_9/0 const_lo", 64'(lo), 64'd15);
        run_op("mul_6x7_busy", 1'b0, 32'd6, 32'd7, 1'b1, 1'b1);
        chk("mul_6x7 const_lo", 64'(lo), 64'd42);

        for (int i = 0; i < 24; i++) begin
            ro = 1'($urandom_range(0, 1));
            ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : W'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : W'($urandom);
            if ($urandom_range(0, 2) == 0) rb = rb >> $urandom_range(16, 31);
            run_op($sformatf("rand%0d_%s", i, ro ? "div" : "mul"), ro, ra, rb, 1'b0, 1'b0);
        end

        run_op("mul_pre_rst", 1'b0, 32'd1234, 32'hFFFF_F000, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b1; op = 1'b1; operand_a = 32'hFFFF_FF9C; operand_b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("pre_rst busy", 64'(busy), 64'd1);
        #2 reset = 1'b1;
        #1;
        exp_hi = '0;
        exp_lo = '0;
        chk("async_rst busy", 64'(busy), 64'd0);
        chk("async_rst done", 64'(done), 64'd0);
        chk("async_rst div_zero", 64'(div_zero), 64'd0);
        chk("async_rst hi", 64'(hi), 64'd0);
        chk("async_rst lo", 64'(lo), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        run_op("mul_2x2_post_rst", 1'b0, 32'd2, 32'd2, 1'b0, 1'b0);
        chk("mul_2x2 const_lo", 64'(lo), 64'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
